// File: rtl/piso_stream.sv
// Parallel-in/serial-out converter with valid/ready on both sides, selectable bit order and synchronous flush.
// Optional macro PISO_PARITY_EN appends an even-parity bit after the WIDTH data bits of every word.
module piso_stream #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] par_data,
  input  logic             par_valid,
  output logic             par_ready,
  output logic             ser_q,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next, shreg_shifted;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic             take, accept, is_last, data_bit;

  // Shift toward the output end, zero-filling the vacated end.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST != 0) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_reg[gi+1];
        end
      end
    end
  endgenerate

  assign data_bit  = (MSB_FIRST != 0) ? shreg_reg[WIDTH-1] : shreg_reg[0];
  assign ser_valid = (state_reg == SHIFT);
  assign is_last   = ser_valid && (cnt_reg == LAST_CNT);
  assign ser_last  = is_last;
  assign take      = ser_valid && ser_ready;
  // Combinational ready lets the next word load on the final bit with no bubble.
  assign par_ready = !flush && ((state_reg == IDLE) || (take && is_last));
  assign accept    = par_valid && par_ready;
  assign done      = done_reg;

`ifdef PISO_PARITY_EN
  logic par_reg, par_next;

  assign ser_q = (cnt_reg == LAST_CNT) ? par_reg : data_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_reg <= 1'b0;
    end else begin
      par_reg <= par_next;
    end
  end

  always_comb begin
    par_next = par_reg;
    if (flush) begin
      par_next = 1'b0;
    end else if (accept) begin
      par_next = ^par_data;
    end
  end
`else
  assign ser_q = data_bit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  // accept can only happen in IDLE or on the final take, so it covers both load cases.
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    if (flush) begin
      state_next = IDLE;
      shreg_next = '0;
      cnt_next   = '0;
    end else begin
      done_next = take && is_last;
      if (accept) begin
        state_next = SHIFT;
        shreg_next = par_data;
        cnt_next   = '0;
      end else if (take) begin
        if (is_last) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          shreg_next = shreg_shifted;
          cnt_next   = cnt_reg + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream: a 4-bit MSB-first and an 8-bit LSB-first instance against a word/index model.
module tb_piso_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] flush_s, par_valid_s, ser_ready_s;
  logic [3:0] pd4;
  logic [7:0] pd8;
  logic [1:0] par_ready_o, ser_q_o, ser_valid_o, ser_last_o, done_o;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_busy[2];
  int          m_idx[2];
  logic [63:0] m_word[2];
  bit          m_done[2];

  piso_stream #(.WIDTH(4), .MSB_FIRST(1)) u_d4 (
    .clk(clk), .reset(reset), .flush(flush_s[0]),
    .par_data(pd4), .par_valid(par_valid_s[0]), .par_ready(par_ready_o[0]),
    .ser_q(ser_q_o[0]), .ser_valid(ser_valid_o[0]), .ser_ready(ser_ready_s[0]),
    .ser_last(ser_last_o[0]), .done(done_o[0])
  );

  piso_stream #(.WIDTH(8), .MSB_FIRST(0)) u_d8 (
    .clk(clk), .reset(reset), .flush(flush_s[1]),
    .par_data(pd8), .par_valid(par_valid_s[1]), .par_ready(par_ready_o[1]),
    .ser_q(ser_q_o[1]), .ser_valid(ser_valid_o[1]), .ser_ready(ser_ready_s[1]),
    .ser_last(ser_last_o[1]), .done(done_o[1])
  );

  function automatic int wid(int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic int nbits(int i);
    return wid(i) + PAR;
  endfunction

  function automatic logic [63:0] pdata(int i);
    return (i == 0) ? {60'b0, pd4} : {56'b0, pd8};
  endfunction

  // Bit number idx of the word in transmission order; index WIDTH is the parity bit.
  function automatic logic exp_bit(int i);
    int          w;
    logic [63:0] wd;
    w  = wid(i);
    wd = m_word[i];
    if (m_idx[i] == w) return ^wd;
    return (i == 0) ? wd[w-1-m_idx[i]] : wd[m_idx[i]];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0;
      m_idx[i]  = 0;
      m_done[i] = 0;
      m_word[i] = '0;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      bit sv, last, take, pr;
      sv   = m_busy[i];
      last = sv && (m_idx[i] == nbits(i) - 1);
      take = sv && ser_ready_s[i];
      pr   = !flush_s[i] && (!sv || (take && last));
      check($sformatf("d%0d par_ready", i), 64'(par_ready_o[i]), 64'(pr));
      check($sformatf("d%0d ser_valid", i), 64'(ser_valid_o[i]), 64'(sv));
      check($sformatf("d%0d ser_last", i), 64'(ser_last_o[i]), 64'(last));
      check($sformatf("d%0d done", i), 64'(done_o[i]), 64'(m_done[i]));
      if (sv) check($sformatf("d%0d ser_q bit%0d", i, m_idx[i]), 64'(ser_q_o[i]), 64'(exp_bit(i)));
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      bit sv, last, take, pr;
      sv   = m_busy[i];
      last = sv && (m_idx[i] == nbits(i) - 1);
      take = sv && ser_ready_s[i];
      pr   = !flush_s[i] && (!sv || (take && last));
      if (flush_s[i]) begin
        m_busy[i] = 0;
        m_idx[i]  = 0;
        m_done[i] = 0;
      end else begin
        m_done[i] = take && last;
        if (pr && par_valid_s[i]) begin
          m_word[i] = pdata(i);
          m_idx[i]  = 0;
          m_busy[i] = 1;
        end else if (take) begin
          if (last) begin
            m_busy[i] = 0;
            m_idx[i]  = 0;
          end else begin
            m_idx[i]++;
          end
        end
      end
    end
  endtask

  // Inputs change only at posedge+1, so they are stable across both the check and the edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic drain();
    par_valid_s = 2'b00;
    flush_s     = 2'b00;
    ser_ready_s = 2'b11;
    for (int k = 0; k < 20 && (m_busy[0] || m_busy[1]); k++) tick();
    tick();
  endtask

  logic [3:0] got4;
  logic [9:0] got10;
  logic [9:0] exp10;

  initial begin
    reset       = 1'b0;
    flush_s     = 2'b00;
    par_valid_s = 2'b00;
    ser_ready_s = 2'b11;
    pd4         = '0;
    pd8         = '0;
    #1 reset = 1'b1;
    #1;
    check("reset par_ready", 64'(par_ready_o), 64'(2'b11));
    check("reset ser_valid", 64'(ser_valid_o), 64'(2'b00));
    check("reset ser_last", 64'(ser_last_o), 64'(2'b00));
    check("reset done", 64'(done_o), 64'(2'b00));
    check("reset ser_q", 64'(ser_q_o), 64'(2'b00));
    model_reset();
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // MSB-first 1001
    pd4 = 4'b1001;
    par_valid_s = 2'b01;
    tick();
    par_valid_s = 2'b00;
    got4 = '0;
    for (int k = 0; k < 4; k++) begin
      got4[3-k] = ser_q_o[0];
      tick();
    end
    check("d0 msb seq 1001", 64'(got4), 64'(4'b1001));
    drain();

    // Back-to-back 1011 then 1000 with par_valid held
    pd4 = 4'b1011;
    par_valid_s = 2'b01;
    tick();
    pd4 = 4'b1000;
    got10 = '0;
    for (int k = 0; k < 2 * nbits(0); k++) begin
      got10 = {got10[8:0], ser_q_o[0]};
      tick();
      if (k == nbits(0) - 1) par_valid_s = 2'b00;
    end
`ifdef PISO_PARITY_EN
    exp10 = 10'b1011110001;
`else
    exp10 = 10'b0010111000;
`endif
    check("d0 back-to-back seq", 64'(got10), 64'(exp10));
    drain();

    // LSB-first with a three-cycle consumer stall on the first bit
    pd8 = 8'h01;
    par_valid_s = 2'b10;
    tick();
    par_valid_s = 2'b00;
    ser_ready_s = 2'b01;
    for (int k = 0; k < 3; k++) begin
      check("d1 stall hold q", 64'(ser_q_o[1]), 64'(1'b1));
      tick();
    end
    drain();

    // Flush after three bits, then a fresh word
    pd8 = 8'hA5;
    par_valid_s = 2'b10;
    tick();
    par_valid_s = 2'b00;
    for (int k = 0; k < 3; k++) tick();
    flush_s = 2'b10;
    pd8 = 8'h5A;
    par_valid_s = 2'b10;
    tick();
    flush_s = 2'b00;
    par_valid_s = 2'b00;
    check("d1 flush ser_valid", 64'(ser_valid_o[1]), 64'(1'b0));
    check("d1 flush done", 64'(done_o[1]), 64'(1'b0));
    pd8 = 8'h3C;
    par_valid_s = 2'b10;
    tick();
    par_valid_s = 2'b00;
    drain();

    // Asynchronous reset in the middle of a word
    pd4 = 4'hF;
    pd8 = 8'hFF;
    par_valid_s = 2'b11;
    tick();
    par_valid_s = 2'b00;
    tick();
    #1 reset = 1'b1;
    #1;
    check("mid reset par_ready", 64'(par_ready_o), 64'(2'b11));
    check("mid reset ser_valid", 64'(ser_valid_o), 64'(2'b00));
    check("mid reset ser_last", 64'(ser_last_o), 64'(2'b00));
    check("mid reset done", 64'(done_o), 64'(2'b00));
    check("mid reset ser_q", 64'(ser_q_o), 64'(2'b00));
    model_reset();
    reset = 1'b0;
    tick();

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      flush_s     = {($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0)};
      par_valid_s = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      ser_ready_s = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      pd4         = 4'($urandom);
      pd8         = 8'($urandom);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
